tree_drain: RTL and testbench
=============================

# tree_drain

Output-side drain for the 10-bit tree register pipeline. The tree stages move data every cycle with no flow control. This block accepts their results with a valid qualifier, buffers them in a small FIFO, and hands them to a back-pressured consumer over a valid/ready handshake. It also reports occupancy, an early stall hint, and a sticky overflow flag so upstream control can throttle the tree.

## Interface
- DATA_W, 10, payload width (pixel/sample width of the tree)
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  tree result present this cycle
- in_data  input  DATA_W  tree result
- out_ready  input  1  consumer accepts out_data this cycle
- ovf_clr  input  1  clears sticky overflow
- out_valid  output  1  out_data holds valid head entry
- out_data  output  DATA_W  head-of-FIFO data
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- almost_full  output  1  level ≥ DEPTH-1
- overflow  output  1  sticky: a push was dropped

## Operation
- Push: in_valid=1 and (level<DEPTH or pop this cycle) → in_data is written at the write pointer.
- Pop: out_valid=1 and out_ready=1 → the head is consumed and the read pointer advances.
- Drop: in_valid=1, level==DEPTH and no pop in the same cycle → data is discarded, overflow is set, and level is unchanged.
- Simultaneous push and pop:
  - at any level, including full, both occur and level is unchanged;
  - at level 0 no pop is possible, so it is a plain push.
- Pointers are DEPTH-modulo and wrap naturally. Occupancy is tracked by an explicit counter, not by pointer difference.
- FIFO ordering is strict. No entry is duplicated or reordered.
- out_data is the registered head of the FIFO (first-word fall-through). It holds stable while out_valid=1 and out_ready=0.
- out_valid = (level != 0).
- overflow:
  - set by any drop;
  - cleared by ovf_clr;
  - if a drop and ovf_clr occur in the same cycle, set wins.
- almost_full is combinational from level. There is no other combinational path from inputs to outputs.
- Reset values:
  - out_valid=0, out_data=0, level=0, almost_full=0, overflow=0;
  - both pointers 0.
  - Storage contents need not be reset.
- Reset mid-operation:
  - all buffered data is lost;
  - outputs take their reset values immediately (asynchronous);
  - the first push after deassertion behaves as a push into an empty FIFO.

## Timing
- Latency: push on cycle N into an empty FIFO gives out_valid=1 and out_data=that value from cycle N+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles while out_ready=1.
- level, almost_full and overflow update on the clock edge that performs the push, pop or drop.
- Pop on cycle N exposes the next entry on out_data from cycle N+1, or out_valid=0 if the FIFO is now empty.
- out_ready is sampled only when out_valid=1. It is ignored when the FIFO is empty.
- rst deassertion is synchronised externally. The block acts on the first rising edge after release.

## Structure
- Shared package dbmc_pkg:
  - DATA_W=10;
  - typedef pixel_t (logic [DATA_W-1:0]);
  - the DEPTH default.
- The package is reused by the tree stages so that widths match.
- One sub-module, drain_mem:
  - DEPTH×DATA_W register array;
  - write port (we, waddr, wdata) and registered read (raddr → rdata);
  - no reset on the array.
- tree_drain owns the pointers, level counter, handshake and flag logic.

## Test plan
- Reset check: assert rst mid-stream with level=3 → all outputs read 0 asynchronously. After release, push 0x155 → out_valid=1 and out_data=0x155 one cycle later, level=1.
- Fill and drain:
  - stimulus: push 0x001..0x004 with out_ready=0;
  - then: level=4, almost_full=1 after the third push;
  - then: raise out_ready → 0x001..0x004 appear in order on 4 consecutive cycles, then out_valid=0, level=0.
- Overflow:
  - stimulus: FIFO full, out_ready=0, push 0x3FF → dropped, overflow=1, level=4;
  - then: drain → 0x3FF never appears;
  - then: ovf_clr pulse → overflow=0.
- Full plus simultaneous push/pop: level=4, out_ready=1, push 0x2AA → accepted, level stays 4, and 0x2AA emerges fifth in order.
- Streaming with wrap: push 0x000..0x013 (20 values) continuously with out_ready=1 → identical sequence out at 1-cycle latency, level ≤ 1, pointers wrap 5 times, overflow=0.
- Clear/set collision: a drop and ovf_clr in the same cycle → overflow=1.

Source files
------------

// File: rtl/dbmc_pkg.sv
// Shared widths and defaults for the tree register pipeline and its output drain.
package dbmc_pkg;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 4;

  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/drain_mem.sv
// Storage array for tree_drain: one write port and a registered read port that
// forwards same-cycle write data, so that a freshly pushed head is visible one cycle later.
module drain_mem #(
  parameter int DATA_W = dbmc_pkg::DATA_W,
  parameter int DEPTH  = dbmc_pkg::DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset; every entry is written before it can be read,
  // and leaving it unreset lets it map onto plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = mem_q[raddr];
    if (we && (waddr == raddr)) rdata_d = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tree_drain.sv
// Output-side drain for the tree pipeline: valid-qualified input, small FIFO,
// valid/ready output, occupancy, almost-full hint and sticky overflow flag.
module tree_drain #(
  parameter int DATA_W = dbmc_pkg::DATA_W,
  parameter int DEPTH  = dbmc_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   out_ready,
  input  logic                   ovf_clr,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [LVL_W-1:0] level_d, level_q;
  logic             overflow_d, overflow_q;
  logic             push, pop, drop;

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    pop        = (level_q != '0) && out_ready;
    push       = in_valid && ((level_q != LVL_FULL) || pop);
    drop       = in_valid && (level_q == LVL_FULL) && !pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Reading at the next read pointer keeps out_data holding the head after each edge.
  drain_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_d),
    .rdata (out_data)
  );

  assign out_valid   = (level_q != '0);
  assign level       = level_q;
  assign almost_full = (level_q >= LVL_AF);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_tree_drain.sv
// Directed self-checking bench for tree_drain with hand-computed expectations.
module tb_tree_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [9:0] in_data;
  logic       out_ready;
  logic       ovf_clr;
  logic       out_valid;
  logic [9:0] out_data;
  logic [2:0] level;
  logic       almost_full;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  tree_drain dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .ovf_clr     (ovf_clr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_af"},    32'(almost_full), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
  endtask

  logic [9:0] exp_seq [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Reset mid-stream with three entries buffered.
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 10'(i * 'h11);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 3);
    check("pre_rst_head", 32'(out_data), 'h011);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 10'h155;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", 32'(out_data), 'h155);
    check("post_rst_level", 32'(level), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", 32'(out_valid), 0);

    // Fill to full with the consumer stalled.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 10'(i);
      tick();
      check($sformatf("fill_level_%0d", i), 32'(level), 32'(i));
      check($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 3) ? 1 : 0);
      check($sformatf("fill_head_%0d", i), 32'(out_data), 'h001);
    end

    // Push into a full FIFO with no pop is dropped.
    in_data = 10'h3FF;
    tick();
    check("drop_ovf", 32'(overflow), 1);
    check("drop_level", 32'(level), 4);
    check("drop_head_stable", 32'(out_data), 'h001);

    // Full with simultaneous push and pop keeps level at 4.
    out_ready = 1'b1; in_data = 10'h2AA;
    tick();
    in_valid = 1'b0;
    check("fullpp_level", 32'(level), 4);
    exp_seq[0] = 10'h002; exp_seq[1] = 10'h003; exp_seq[2] = 10'h004; exp_seq[3] = 10'h2AA;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(out_valid), 1);
      check($sformatf("drain_data_%0d", k), 32'(out_data), 32'(exp_seq[k]));
      tick();
    end
    check("drain_empty_valid", 32'(out_valid), 0);
    check("drain_empty_level", 32'(level), 0);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // Empty FIFO ignores out_ready.
    tick();
    check("idle_level", 32'(level), 0);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // Drop and clear in the same cycle: set wins.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 10'('h100 + i);
      tick();
    end
    check("coll_full_level", 32'(level), 4);
    ovf_clr = 1'b1; in_data = 10'h0AB;
    tick();
    in_valid = 1'b0;
    check("coll_ovf_set", 32'(overflow), 1);
    check("coll_level", 32'(level), 4);
    tick();
    ovf_clr = 1'b0;
    check("coll_ovf_clr", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("coll_drain_%0d", k), 32'(out_data), 32'('h100 + k));
      tick();
    end
    check("coll_empty", 32'(out_valid), 0);

    // Continuous streaming at one word per cycle across several pointer wraps.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 10'(i);
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("stream_data_%0d", i), 32'(out_data), 32'(i));
      check($sformatf("stream_level_%0d", i), 32'(level), 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 0);
    check("stream_end_level", 32'(level), 0);
    check("stream_end_ovf", 32'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
